icache_line_buffer: RTL and testbench

- Responder side of the ICache_valid/ICache_ready fetch handshake: accepts fetch requests from IF1 and returns instructions.
- Hits are served from a single refillable instruction line; a miss triggers a burst read from the memory-side read port.
- ICache_ready stays low while the block is busy, so the fetch-side controller stalls the PC and flushes IF1/ID.

---
 rtl/icache_line_buffer.sv | 128 ++++++++++++
 tb/tb_icache_line_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_buffer.sv
// Single-line instruction buffer answering the IF1 fetch handshake.
// Hits are served combinationally; misses refill the line with one memory burst.
module icache_line_buffer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ICache_valid,
    input  logic [ADDR_W-1:0] ICache_addr,
    output logic              ICache_ready,
    output logic [31:0]       ICache_inst,
    input  logic              invalidate,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [31:0]       ret_data
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam int unsigned TAG_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRefill,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_line_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       r_line [LINE_WORDS];
    logic [IDX_W-1:0]  r_cnt;
    logic              r_drop;
    logic [ADDR_W-1:0] r_rd_addr;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_miss;
    logic              w_unused;

    assign w_tag    = ICache_addr[ADDR_W-1:OFF_W];
    assign w_idx    = ICache_addr[OFF_W-1:2];
    assign w_hit    = (r_state == StIdle) && r_line_valid && (w_tag == r_tag);
    assign w_miss   = ICache_valid && !w_hit && !invalidate;
    assign w_unused = ^ICache_addr[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_miss) w_state_next = StReq;
            StReq:    if (rd_rdy) w_state_next = StRefill;
            StRefill: if (ret_valid && ret_last) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        rd_req       = (r_state == StReq);
        rd_addr      = r_rd_addr;
        ICache_ready = ICache_valid && w_hit && !invalidate;
        ICache_inst  = r_line[w_idx];
    end

    // Line storage, tag, burst address and refill bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
            r_rd_addr    <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (invalidate) begin
                        r_line_valid <= 1'b0;
                    end else if (ICache_valid && !w_hit) begin
                        r_rd_addr <= {w_tag, {OFF_W{1'b0}}};
                    end
                end
                StReq: begin
                    if (invalidate) r_drop <= 1'b1;
                    if (rd_rdy) r_cnt <= '0;
                end
                StRefill: begin
                    if (invalidate) r_drop <= 1'b1;
                    if (ret_valid) begin
                        r_line[r_cnt] <= ret_data;
                        r_cnt         <= r_cnt + IDX_W'(1);
                        if (ret_last) begin
                            r_tag        <= r_rd_addr[ADDR_W-1:OFF_W];
                            r_line_valid <= !(r_drop || invalidate);
                            r_drop       <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    // Drop was already consumed at the last beat, so kill the line directly.
                    if (invalidate) r_line_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_buffer.sv
// Directed bench for icache_line_buffer: fills, hits, backpressure, invalidates, reset.
module tb_icache_line_buffer;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] inst;
    logic        inval;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int n_vec;
    int n_bad;

    icache_line_buffer #(
        .ADDR_W     (32),
        .LINE_WORDS (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ICache_valid (valid),
        .ICache_addr  (addr),
        .ICache_ready (ready),
        .ICache_inst  (inst),
        .invalidate   (inval),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // One return beat per cycle; last flagged on the final one.
    task automatic burst(input logic [31:0] base, input int beats, input int inval_at);
        for (int i = 0; i < beats; i++) begin
            ret_valid = 1'b1;
            ret_data  = base + 32'(i);
            ret_last  = (i == beats - 1);
            inval     = (i == inval_at);
            settle();
            check_eq("refill_rdy", 32'(ready), 32'd0);
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        inval     = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rstn      = 1'b0;
        valid     = 1'b0;
        addr      = '0;
        inval     = 1'b0;
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        tick();
        tick();
        settle();
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rd_req", 32'(rd_req), 32'd0);
        check_eq("rst_rd_addr", rd_addr, 32'h0);
        check_eq("rst_inst", inst, 32'h0);

        // Cold miss
        rstn  = 1'b1;
        valid = 1'b1;
        addr  = 32'h1C00_0008;
        settle();
        check_eq("cold_idle_rdy", 32'(ready), 32'd0);
        check_eq("cold_idle_req", 32'(rd_req), 32'd0);
        tick();
        settle();
        check_eq("cold_req", 32'(rd_req), 32'd1);
        check_eq("cold_rd_addr", rd_addr, 32'h1C00_0000);
        check_eq("cold_req_rdy", 32'(ready), 32'd0);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        settle();
        check_eq("cold_req_once", 32'(rd_req), 32'd0);
        burst(32'hA0, 4, -1);
        settle();
        check_eq("cold_done_rdy", 32'(ready), 32'd0);
        tick();
        settle();
        check_eq("cold_hit_rdy", 32'(ready), 32'd1);
        check_eq("cold_hit_inst", inst, 32'hA2);

        // Sequential hits across the whole line
        for (int i = 0; i < 4; i++) begin
            addr = 32'h1C00_0000 + 32'(4 * i);
            settle();
            check_eq("seq_rdy", 32'(ready), 32'd1);
            check_eq("seq_inst", inst, 32'hA0 + 32'(i));
            check_eq("seq_req", 32'(rd_req), 32'd0);
            tick();
        end

        // Line-crossing miss, memory stalls three cycles
        addr = 32'h1C00_0010;
        settle();
        check_eq("cross_miss_rdy", 32'(ready), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_rdy = (i == 3);
            settle();
            check_eq("bp_req", 32'(rd_req), 32'd1);
            check_eq("bp_rd_addr", rd_addr, 32'h1C00_0010);
            check_eq("bp_rdy", 32'(ready), 32'd0);
            tick();
        end
        rd_rdy = 1'b0;
        addr   = 32'h1C00_0004;
        burst(32'hB0, 4, -1);
        addr = 32'h1C00_0010;
        settle();
        check_eq("bp_done_rdy", 32'(ready), 32'd0);
        tick();
        settle();
        check_eq("bp_hit_rdy", 32'(ready), 32'd1);
        check_eq("bp_hit_inst", inst, 32'hB0);
        addr = 32'h1C00_001C;
        settle();
        check_eq("bp_hit3_inst", inst, 32'hB3);
        addr = 32'h1C00_0004;
        settle();
        check_eq("old_line_gone", 32'(ready), 32'd0);

        // Invalidate pulse during the burst
        addr = 32'h1C00_0020;
        settle();
        tick();
        rd_rdy = 1'b1;
        settle();
        check_eq("inv_req", 32'(rd_req), 32'd1);
        tick();
        rd_rdy = 1'b0;
        burst(32'hC0, 4, 1);
        settle();
        check_eq("inv_done_req", 32'(rd_req), 32'd0);
        check_eq("inv_done_rdy", 32'(ready), 32'd0);
        tick();
        settle();
        check_eq("inv_refetch_rdy", 32'(ready), 32'd0);
        tick();
        settle();
        check_eq("inv_refetch_req", 32'(rd_req), 32'd1);
        check_eq("inv_refetch_addr", rd_addr, 32'h1C00_0020);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        burst(32'hD0, 4, -1);
        tick();
        settle();
        check_eq("refill_hit_rdy", 32'(ready), 32'd1);
        check_eq("refill_hit_inst", inst, 32'hD0);

        // Invalidate while idle on a hit address
        addr  = 32'h1C00_0024;
        inval = 1'b1;
        settle();
        check_eq("idle_inv_rdy", 32'(ready), 32'd0);
        tick();
        inval = 1'b0;
        settle();
        check_eq("idle_inv_next_rdy", 32'(ready), 32'd0);
        tick();
        settle();
        check_eq("idle_inv_req", 32'(rd_req), 32'd1);

        // Reset after two beats of the refill
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1;
            ret_data  = 32'hE0 + 32'(i);
            tick();
        end
        ret_valid = 1'b0;
        rstn      = 1'b0;
        tick();
        settle();
        check_eq("mid_rst_rdy", 32'(ready), 32'd0);
        check_eq("mid_rst_req", 32'(rd_req), 32'd0);
        check_eq("mid_rst_inst", inst, 32'h0);
        rstn      = 1'b1;
        ret_valid = 1'b1;
        ret_last  = 1'b1;
        ret_data  = 32'hE3;
        settle();
        check_eq("post_rst_rdy", 32'(ready), 32'd0);
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        settle();
        check_eq("post_rst_req", 32'(rd_req), 32'd1);
        check_eq("post_rst_addr", rd_addr, 32'h1C00_0020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
